// File: rtl/sdram_cmd_pkg.sv
// Shared constants for the SDRAM pin-bus command monitor: command/error codes,
// ras/cas/we pin patterns, bank timer width and the sampled-pin bundle.
package sdram_cmd_pkg;

   localparam logic [3:0] CMD_DESL  = 4'd0;
   localparam logic [3:0] CMD_NOP   = 4'd1;
   localparam logic [3:0] CMD_MRS   = 4'd2;
   localparam logic [3:0] CMD_ACT   = 4'd3;
   localparam logic [3:0] CMD_READ  = 4'd4;
   localparam logic [3:0] CMD_READA = 4'd5;
   localparam logic [3:0] CMD_WRIT  = 4'd6;
   localparam logic [3:0] CMD_WRITA = 4'd7;
   localparam logic [3:0] CMD_PRE   = 4'd8;
   localparam logic [3:0] CMD_PALL  = 4'd9;
   localparam logic [3:0] CMD_BST   = 4'd10;
   localparam logic [3:0] CMD_REF   = 4'd11;
   localparam logic [3:0] CMD_SELF  = 4'd12;
   localparam logic [3:0] CMD_SUP   = 4'd13;
   localparam logic [3:0] CMD_REC   = 4'd14;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
   localparam logic [2:0] ERR_RW_IDLE   = 3'd2;
   localparam logic [2:0] ERR_RCD       = 3'd3;
   localparam logic [2:0] ERR_RP_RC     = 3'd4;
   localparam logic [2:0] ERR_BANK_OPEN = 3'd5;
   localparam logic [2:0] ERR_MRD       = 3'd6;

   // {ras, cas, we}, active-low
   localparam logic [2:0] PAT_MRS  = 3'b000;
   localparam logic [2:0] PAT_REF  = 3'b001;
   localparam logic [2:0] PAT_PRE  = 3'b010;
   localparam logic [2:0] PAT_ACT  = 3'b011;
   localparam logic [2:0] PAT_WRIT = 3'b100;
   localparam logic [2:0] PAT_READ = 3'b101;
   localparam logic [2:0] PAT_BST  = 3'b110;
   localparam logic [2:0] PAT_NOP  = 3'b111;

   localparam int unsigned           TIMER_W   = 4;
   localparam logic [TIMER_W-1:0]    TIMER_SAT = '1;

   typedef struct packed {
      logic        cke;
      logic        cs;
      logic        ras;
      logic        cas;
      logic        we;
      logic [1:0]  ba;
      logic [11:0] addr;
   } pins_t;

   function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
      return (t == TIMER_SAT) ? t : t + TIMER_W'(1);
   endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One SDRAM bank: open flag, open row and saturating ACT/precharge timers,
// with timing-check flags as seen by a command decoded this cycle.
module sdram_bank_tracker
   import sdram_cmd_pkg::*;
#(
   parameter int unsigned T_RCD = 3,
   parameter int unsigned T_RP  = 3,
   parameter int unsigned T_RC  = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        act_i,
   input  logic        close_i,
   input  logic [11:0] row_i,
   output logic        open_o,
   output logic [11:0] row_o,
   output logic        rcd_ok_o,
   output logic        rp_ok_o,
   output logic        rc_ok_o
);

   localparam logic [TIMER_W-1:0] RCD_L = TIMER_W'(T_RCD);
   localparam logic [TIMER_W-1:0] RP_L  = TIMER_W'(T_RP);
   localparam logic [TIMER_W-1:0] RC_L  = TIMER_W'(T_RC);

   logic               open_q;
   logic [11:0]        row_q;
   logic [TIMER_W-1:0] t_act_q;
   logic [TIMER_W-1:0] t_pre_q;
   logic [TIMER_W-1:0] t_act_seen;
   logic [TIMER_W-1:0] t_pre_seen;

   // Timers hold cycles since the event minus one; add one to get the
   // spacing the command being decoded now actually has.
   always_comb begin
      t_act_seen = timer_inc(t_act_q);
      t_pre_seen = timer_inc(t_pre_q);
      rcd_ok_o   = (t_act_seen >= RCD_L);
      rc_ok_o    = (t_act_seen >= RC_L);
      rp_ok_o    = (t_pre_seen >= RP_L);
      open_o     = open_q;
      row_o      = row_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q  <= 1'b0;
         row_q   <= '0;
         t_act_q <= TIMER_SAT;
         t_pre_q <= TIMER_SAT;
      end else begin
         t_act_q <= act_i ? '0 : timer_inc(t_act_q);
         t_pre_q <= close_i ? '0 : timer_inc(t_pre_q);
         if (act_i) begin
            open_q <= 1'b1;
            // ACT to an already open bank keeps the original row
            if (!open_q) row_q <= row_i;
         end else if (close_i) begin
            open_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdram_cmd_monitor.sv
// SDRAM pin-bus command decoder and protocol checker (latency 1 after sampling).
// Optional macro SDRAM_MON_STATS_EN adds saturating read/write/refresh counters.
module sdram_cmd_monitor
   import sdram_cmd_pkg::*;
#(
   parameter int unsigned T_RCD = 3,
   parameter int unsigned T_RP  = 3,
   parameter int unsigned T_RC  = 9,
   parameter int unsigned T_MRD = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cke_i,
   input  logic        cs_i,
   input  logic        ras_i,
   input  logic        cas_i,
   input  logic        we_i,
   input  logic [1:0]  ba_i,
   input  logic [11:0] addr_i,
   output logic        cmd_valid_o,
   output logic [3:0]  cmd_code_o,
   output logic [1:0]  cmd_ba_o,
   output logic [11:0] cmd_addr_o,
   output logic [3:0]  bank_open_o,
   output logic [47:0] bank_row_o,
   output logic        err_valid_o,
   output logic [2:0]  err_code_o
`ifdef SDRAM_MON_STATS_EN
   ,
   output logic [15:0] rd_count_o,
   output logic [15:0] wr_count_o,
   output logic [15:0] ref_count_o
`endif
);

   localparam logic [TIMER_W-1:0] MRD_L = TIMER_W'(T_MRD);

   pins_t              pins_q;
   logic               cke_prev_q;
   logic [TIMER_W-1:0] t_mrd_q;
   logic               dec_valid;
   logic [3:0]         dec_code;
   logic [2:0]         pat;
   logic [3:0]         act_w, close_w, open_w, rcd_ok_w, rp_ok_w, rc_ok_w;
   logic [11:0]        row_w [4];
   logic               is_rw;
   logic [2:0]         err_d;

   always_comb begin
      pat       = {pins_q.ras, pins_q.cas, pins_q.we};
      dec_valid = 1'b1;
      dec_code  = CMD_DESL;
      if (cke_prev_q && pins_q.cke) begin
         if (!pins_q.cs) begin
            unique case (pat)
               PAT_NOP:  dec_code = CMD_NOP;
               PAT_MRS:  dec_code = CMD_MRS;
               PAT_ACT:  dec_code = CMD_ACT;
               PAT_READ: dec_code = pins_q.addr[10] ? CMD_READA : CMD_READ;
               PAT_WRIT: dec_code = pins_q.addr[10] ? CMD_WRITA : CMD_WRIT;
               PAT_PRE:  dec_code = pins_q.addr[10] ? CMD_PALL : CMD_PRE;
               PAT_BST:  dec_code = CMD_BST;
               PAT_REF:  dec_code = CMD_REF;
               default:  dec_code = CMD_NOP;
            endcase
         end
      end else if (cke_prev_q) begin
         dec_code = (!pins_q.cs && pat == PAT_REF) ? CMD_SELF : CMD_SUP;
      end else if (pins_q.cke) begin
         dec_code = CMD_REC;
      end else begin
         dec_valid = 1'b0;
      end
   end

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         act_w[b]   = dec_valid && dec_code == CMD_ACT && pins_q.ba == 2'(b);
         close_w[b] = dec_valid && ((dec_code == CMD_PALL) ||
                      ((dec_code inside {CMD_PRE, CMD_READA, CMD_WRITA}) && pins_q.ba == 2'(b)));
         bank_row_o[12*b +: 12] = row_w[b];
      end
      bank_open_o = open_w;
   end

   for (genvar g = 0; g < 4; g++) begin : g_bank
      sdram_bank_tracker #(
         .T_RCD (T_RCD),
         .T_RP  (T_RP),
         .T_RC  (T_RC)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .act_i    (act_w[g]),
         .close_i  (close_w[g]),
         .row_i    (pins_q.addr),
         .open_o   (open_w[g]),
         .row_o    (row_w[g]),
         .rcd_ok_o (rcd_ok_w[g]),
         .rp_ok_o  (rp_ok_w[g]),
         .rc_ok_o  (rc_ok_w[g])
      );
   end

   // Priority chain: lowest error code wins
   always_comb begin
      is_rw = dec_code inside {CMD_READ, CMD_READA, CMD_WRIT, CMD_WRITA};
      err_d = ERR_NONE;
      if (dec_valid) begin
         if (dec_code == CMD_ACT && open_w[pins_q.ba]) begin
            err_d = ERR_ACT_OPEN;
         end else if (is_rw && !open_w[pins_q.ba]) begin
            err_d = ERR_RW_IDLE;
         end else if (is_rw && !rcd_ok_w[pins_q.ba]) begin
            err_d = ERR_RCD;
         end else if (dec_code == CMD_ACT && (!rp_ok_w[pins_q.ba] || !rc_ok_w[pins_q.ba])) begin
            err_d = ERR_RP_RC;
         end else if ((dec_code inside {CMD_MRS, CMD_REF, CMD_SELF}) && (|open_w)) begin
            err_d = ERR_BANK_OPEN;
         end else if (!(dec_code inside {CMD_NOP, CMD_DESL}) && timer_inc(t_mrd_q) < MRD_L) begin
            err_d = ERR_MRD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pins_q      <= '{cke: 1'b1, cs: 1'b1, ras: 1'b1, cas: 1'b1, we: 1'b1,
                          ba: 2'd0, addr: 12'd0};
         cke_prev_q  <= 1'b1;
         t_mrd_q     <= TIMER_SAT;
         cmd_valid_o <= 1'b0;
         cmd_code_o  <= CMD_DESL;
         cmd_ba_o    <= '0;
         cmd_addr_o  <= '0;
         err_valid_o <= 1'b0;
         err_code_o  <= ERR_NONE;
      end else begin
         pins_q      <= '{cke: cke_i, cs: cs_i, ras: ras_i, cas: cas_i, we: we_i,
                          ba: ba_i, addr: addr_i};
         cke_prev_q  <= pins_q.cke;
         t_mrd_q     <= (dec_valid && dec_code == CMD_MRS) ? '0 : timer_inc(t_mrd_q);
         cmd_valid_o <= dec_valid;
         cmd_code_o  <= dec_valid ? dec_code : CMD_DESL;
         cmd_ba_o    <= pins_q.ba;
         cmd_addr_o  <= pins_q.addr;
         err_valid_o <= (err_d != ERR_NONE);
         err_code_o  <= err_d;
      end
   end

`ifdef SDRAM_MON_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_o  <= '0;
         wr_count_o  <= '0;
         ref_count_o <= '0;
      end else if (dec_valid) begin
         if ((dec_code inside {CMD_READ, CMD_READA}) && rd_count_o != 16'hFFFF)
            rd_count_o <= rd_count_o + 16'd1;
         if ((dec_code inside {CMD_WRIT, CMD_WRITA}) && wr_count_o != 16'hFFFF)
            wr_count_o <= wr_count_o + 16'd1;
         if (dec_code == CMD_REF && ref_count_o != 16'hFFFF)
            ref_count_o <= ref_count_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Table-driven bench for sdram_cmd_monitor with a two-deep expectation queue
// matching the sample-then-decode latency, plus a mid-operation reset sequence.
module tb_sdram_cmd_monitor;

   // {cs, ras, cas, we}
   localparam logic [3:0] P_DESL = 4'b1111;
   localparam logic [3:0] P_NOP  = 4'b0111;
   localparam logic [3:0] P_MRS  = 4'b0000;
   localparam logic [3:0] P_ACT  = 4'b0011;
   localparam logic [3:0] P_READ = 4'b0101;
   localparam logic [3:0] P_WRIT = 4'b0100;
   localparam logic [3:0] P_PRE  = 4'b0010;
   localparam logic [3:0] P_BST  = 4'b0110;
   localparam logic [3:0] P_REF  = 4'b0001;

   typedef struct {
      int          idx;
      logic        cke;
      logic [3:0]  pins;
      logic [1:0]  ba;
      logic [11:0] addr;
      logic        chk;
      logic        exp_valid;
      logic [3:0]  exp_code;
      logic [2:0]  exp_err;
      logic [3:0]  exp_open;
      logic        row_chk;
      int          row_bank;
      logic [11:0] exp_row;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cke = 1'b1, cs = 1'b0, ras = 1'b1, cas = 1'b1, we = 1'b1;
   logic [1:0]  ba = '0;
   logic [11:0] addr = '0;
   logic        cmd_valid, err_valid;
   logic [3:0]  cmd_code, bank_open;
   logic [1:0]  cmd_ba;
   logic [11:0] cmd_addr;
   logic [47:0] bank_row;
   logic [2:0]  err_code;
`ifdef SDRAM_MON_STATS_EN
   logic [15:0] rd_count, wr_count, ref_count;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   sdram_cmd_monitor u_dut (
      .clk         (clk),
      .rst         (rst),
      .cke_i       (cke),
      .cs_i        (cs),
      .ras_i       (ras),
      .cas_i       (cas),
      .we_i        (we),
      .ba_i        (ba),
      .addr_i      (addr),
      .cmd_valid_o (cmd_valid),
      .cmd_code_o  (cmd_code),
      .cmd_ba_o    (cmd_ba),
      .cmd_addr_o  (cmd_addr),
      .bank_open_o (bank_open),
      .bank_row_o  (bank_row),
      .err_valid_o (err_valid),
      .err_code_o  (err_code)
`ifdef SDRAM_MON_STATS_EN
      ,
      .rd_count_o  (rd_count),
      .wr_count_o  (wr_count),
      .ref_count_o (ref_count)
`endif
   );

   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add(input logic c, input logic [3:0] p, input logic [1:0] b,
                      input logic [11:0] a, input logic chk, input logic v,
                      input logic [3:0] code, input logic [2:0] err, input logic [3:0] opn,
                      input logic rc, input int rb, input logic [11:0] row);
      vec_t e;
      e.idx = tbl.size(); e.cke = c; e.pins = p; e.ba = b; e.addr = a;
      e.chk = chk; e.exp_valid = v; e.exp_code = code; e.exp_err = err;
      e.exp_open = opn; e.row_chk = rc; e.row_bank = rb; e.exp_row = row;
      tbl.push_back(e);
   endtask

   task automatic compare(input vec_t e);
      check($sformatf("v%0d cmd_valid", e.idx), 48'(cmd_valid), 48'(e.exp_valid));
      check($sformatf("v%0d cmd_code", e.idx), 48'(cmd_code), 48'(e.exp_code));
      check($sformatf("v%0d err_valid", e.idx), 48'(err_valid), 48'(e.exp_err != 3'd0));
      check($sformatf("v%0d err_code", e.idx), 48'(err_code), 48'(e.exp_err));
      check($sformatf("v%0d bank_open", e.idx), 48'(bank_open), 48'(e.exp_open));
      if (e.exp_valid)
         check($sformatf("v%0d cmd_addr", e.idx), 48'(cmd_addr), 48'(e.addr));
      if (e.row_chk)
         check($sformatf("v%0d bank_row[%0d]", e.idx, e.row_bank),
               48'(bank_row[12*e.row_bank +: 12]), 48'(e.exp_row));
   endtask

   // Outputs for a vector are valid two negedges after it is driven
   task automatic cycle(input vec_t v);
      @(negedge clk);
      if (sb.size() >= 2) begin
         vec_t e;
         e = sb.pop_front();
         if (e.chk) compare(e);
      end
      cke = v.cke; {cs, ras, cas, we} = v.pins; ba = v.ba; addr = v.addr;
      sb.push_back(v);
   endtask

   task automatic op(input logic c, input logic [3:0] p, input logic [1:0] b,
                     input logic [11:0] a, input logic chk, input logic [3:0] code,
                     input logic [2:0] err, input logic [3:0] opn);
      vec_t e;
      e.idx = 1000; e.cke = c; e.pins = p; e.ba = b; e.addr = a; e.chk = chk;
      e.exp_valid = 1'b1; e.exp_code = code; e.exp_err = err; e.exp_open = opn;
      e.row_chk = 1'b0; e.row_bank = 0; e.exp_row = '0;
      cycle(e);
   endtask

   initial begin
      for (int i = 0; i < 20; i++) add(1, P_NOP, 0, 0, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
      add(1, P_ACT,  1, 12'h0A5, 1, 1, 3,  0, 4'b0010, 1, 1, 12'h0A5);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0010, 0, 0, 0);
      add(1, P_READ, 1, 12'h010, 1, 1, 4,  3, 4'b0010, 1, 1, 12'h0A5);
      add(1, P_BST,  1, 12'h000, 1, 1, 10, 0, 4'b0010, 0, 0, 0);
      add(1, P_PRE,  1, 12'h000, 1, 1, 8,  0, 4'b0000, 0, 0, 0);
      add(1, P_ACT,  2, 12'h123, 1, 1, 3,  0, 4'b0100, 1, 2, 12'h123);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0100, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0100, 0, 0, 0);
      add(1, P_WRIT, 2, 12'h400, 1, 1, 7,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_ACT,  2, 12'h321, 1, 1, 3,  4, 4'b0100, 1, 2, 12'h321);
      add(1, P_ACT,  2, 12'h055, 1, 1, 3,  1, 4'b0100, 1, 2, 12'h321);
      add(1, P_PRE,  0, 12'h400, 1, 1, 9,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_ACT,  0, 12'h001, 1, 1, 3,  0, 4'b0001, 1, 0, 12'h001);
      add(1, P_REF,  0, 12'h000, 1, 1, 11, 5, 4'b0001, 0, 0, 0);
      add(1, P_PRE,  0, 12'h400, 1, 1, 9,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_REF,  0, 12'h000, 1, 1, 11, 0, 4'b0000, 0, 0, 0);
      add(1, P_MRS,  0, 12'h033, 1, 1, 2,  0, 4'b0000, 0, 0, 0);
      add(1, P_ACT,  3, 12'h0FF, 1, 1, 3,  6, 4'b1000, 1, 3, 12'h0FF);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b1000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b1000, 0, 0, 0);
      add(1, P_READ, 3, 12'h010, 1, 1, 4,  0, 4'b1000, 0, 0, 0);
      add(1, P_WRIT, 3, 12'h020, 1, 1, 6,  0, 4'b1000, 0, 0, 0);
      add(1, P_READ, 3, 12'h400, 1, 1, 5,  0, 4'b0000, 0, 0, 0);
      add(1, P_READ, 3, 12'h010, 1, 1, 4,  2, 4'b0000, 0, 0, 0);
      add(1, P_DESL, 0, 12'h000, 1, 1, 0,  0, 4'b0000, 0, 0, 0);
      add(1, P_MRS,  0, 12'h022, 1, 1, 2,  0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(1, P_PRE,  0, 12'h000, 1, 1, 8,  0, 4'b0000, 0, 0, 0);
      add(1, P_MRS,  0, 12'h022, 1, 1, 2,  0, 4'b0000, 0, 0, 0);
      add(1, P_PRE,  0, 12'h000, 1, 1, 8,  6, 4'b0000, 0, 0, 0);
      add(0, P_REF,  0, 12'h000, 1, 1, 12, 0, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, P_NOP, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 14, 0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 1,  0, 4'b0000, 0, 0, 0);
      add(0, P_NOP,  0, 12'h000, 1, 1, 13, 0, 4'b0000, 0, 0, 0);
      add(1, P_NOP,  0, 12'h000, 1, 1, 14, 0, 4'b0000, 0, 0, 0);

      // Reset state
      #1;
      check("reset cmd_valid", 48'(cmd_valid), 48'd0);
      check("reset cmd_code", 48'(cmd_code), 48'd0);
      check("reset err_valid", 48'(err_valid), 48'd0);
      check("reset bank_open", 48'(bank_open), 48'd0);
      check("reset bank_row", bank_row, 48'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) cycle(tbl[i]);
      op(1, P_ACT, 3, 12'h010, 1, 3, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 1, 1, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 1, 1, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 1, 1, 0, 4'b1000);
      // ACT to open bank 3 is in flight when reset hits
      op(1, P_ACT, 3, 12'h077, 0, 3, 1, 4'b1000);
      @(negedge clk);
      rst = 1'b1;
      cke = 1'b1; {cs, ras, cas, we} = P_NOP; ba = '0; addr = '0;
      #1;
      check("async rst bank_open", 48'(bank_open), 48'd0);
      check("async rst cmd_valid", 48'(cmd_valid), 48'd0);
      @(posedge clk);
      #1;
      check("rst edge bank_open", 48'(bank_open), 48'd0);
      check("rst edge err_valid", 48'(err_valid), 48'd0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      op(1, P_ACT, 3, 12'h0AA, 1, 3, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 1, 1, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 1, 1, 0, 4'b1000);
      op(1, P_NOP, 0, 12'h000, 0, 1, 0, 4'b1000);
      check("post-rst bank_row[3]", 48'(bank_row[47:36]), 48'h0AA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
